// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and helpers for the load/store bus controller.
// Optional feature macro used by the top: LSU_MISALIGN_TRAP_EN.
package lsu_bus_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;

   typedef logic [31:0] RV32I_OPERAND_t;

   // Only LB..SW are memory accesses; the rest exist so the core can hand us
   // something that is not a load/store and get an error back.
   typedef enum logic [3:0] {
      LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, ADDI, BEQ, JAL
   } RV32I_INSTRUCTION_MNEMONIC_t;

   localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
   localparam logic [3:0] LSU_BE_HALF = 4'b0011;
   localparam logic [3:0] LSU_BE_WORD = 4'b1111;

   function automatic logic is_load(RV32I_INSTRUCTION_MNEMONIC_t m);
      return (m == LB) || (m == LH) || (m == LW) || (m == LBU) || (m == LHU);
   endfunction

   function automatic logic is_store(RV32I_INSTRUCTION_MNEMONIC_t m);
      return (m == SB) || (m == SH) || (m == SW);
   endfunction

   function automatic logic is_half(RV32I_INSTRUCTION_MNEMONIC_t m);
      return (m == LH) || (m == LHU) || (m == SH);
   endfunction

   function automatic logic is_word(RV32I_INSTRUCTION_MNEMONIC_t m);
      return (m == LW) || (m == SW);
   endfunction

   // Access is misaligned when its low address bits break natural alignment.
   function automatic logic misaligned(RV32I_INSTRUCTION_MNEMONIC_t m, logic [1:0] lo);
      return (is_half(m) && lo[0]) || (is_word(m) && (lo != 2'b00));
   endfunction

   // Low address bits forced to the natural alignment of the access size.
   function automatic logic [1:0] align_lo(RV32I_INSTRUCTION_MNEMONIC_t m, logic [1:0] lo);
      if (is_word(m)) return 2'b00;
      if (is_half(m)) return {lo[1], 1'b0};
      return lo;
   endfunction

   function automatic logic [3:0] store_be(RV32I_INSTRUCTION_MNEMONIC_t m, logic [1:0] lo);
      if (m == SB) return LSU_BE_BYTE << lo;
      if (m == SH) return LSU_BE_HALF << {lo[1], 1'b0};
      return LSU_BE_WORD;
   endfunction

   // Store data is replicated across all lanes so the bus only needs byte enables.
   function automatic RV32I_OPERAND_t store_wdata(RV32I_INSTRUCTION_MNEMONIC_t m, RV32I_OPERAND_t d);
      if (m == SB) return {4{d[7:0]}};
      if (m == SH) return {2{d[15:0]}};
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero extends.
module lsu_load_align
   import lsu_bus_ctrl_pkg::*;
(
   input  logic [3:0]  mnemonic_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] word_i,
   output logic [31:0] result_o
);

   RV32I_INSTRUCTION_MNEMONIC_t mn;
   logic [31:0]                 lane;

   assign mn   = RV32I_INSTRUCTION_MNEMONIC_t'(mnemonic_i);
   assign lane = word_i >> {addr_lo_i, 3'b000};

   // Extend the selected lane according to access size and signedness.
   always_comb begin
      result_o = lane;
      case (mn)
         LB:      result_o = {{24{lane[7]}}, lane[7:0]};
         LH:      result_o = {{16{lane[15]}}, lane[15:0]};
         LBU:     result_o = {24'h0, lane[7:0]};
         LHU:     result_o = {16'h0, lane[15:0]};
         default: result_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer between the execute stage and the data bus.
// Optional: define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into error
// responses; otherwise low address bits are forced to natural alignment.
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        mnemonic,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wr_data,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wrdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rddata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rddata,
   output logic              rsp_err,
   output logic              stall
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   RV32I_INSTRUCTION_MNEMONIC_t mn;
   lsu_state_t                  state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic                        bus_req_q, bus_we_q, rsp_valid_q, rsp_err_q;
   logic [ADDR_W-1:0]           bus_addr_q;
   logic [3:0]                  bus_be_q, be_d;
   logic [31:0]                 bus_wrdata_q, wdata_d, rsp_rddata_q, load_word;
   logic [3:0]                  mn_q;
   logic [1:0]                  lo_q, lo_d;
   logic                        legal, trap;

   assign mn    = RV32I_INSTRUCTION_MNEMONIC_t'(mnemonic);
   assign legal = is_load(mn) || is_store(mn);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = misaligned(mn, addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   // Bus-side fields derived from the incoming request, latched on accept.
   always_comb begin
      lo_d    = align_lo(mn, addr[1:0]);
      be_d    = is_store(mn) ? store_be(mn, addr[1:0]) : LSU_BE_WORD;
      wdata_d = store_wdata(mn, wr_data);
   end

   lsu_load_align u_align (
      .mnemonic_i (mn_q),
      .addr_lo_i  (lo_q),
      .word_i     (bus_rddata),
      .result_o   (load_word)
   );

   // Access sequencer: IDLE accepts, REQ runs the handshake, RESP pulses the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_be_q     <= '0;
         bus_wrdata_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rddata_q <= '0;
         rsp_err_q    <= 1'b0;
         mn_q         <= '0;
         lo_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (!legal || trap) begin
                     // Rejected without touching the bus.
                     state_q      <= RESP;
                     rsp_valid_q  <= 1'b1;
                     rsp_err_q    <= 1'b1;
                     rsp_rddata_q <= '0;
                  end else begin
                     state_q      <= REQ;
                     cnt_q        <= '0;
                     bus_req_q    <= 1'b1;
                     bus_we_q     <= is_store(mn);
                     bus_addr_q   <= {addr[ADDR_W-1:2], 2'b00};
                     bus_be_q     <= be_d;
                     bus_wrdata_q <= wdata_d;
                     mn_q         <= mnemonic;
                     lo_q         <= lo_d;
                  end
               end
            end
            REQ: begin
               // Ack has priority over a timeout expiring in the same cycle.
               if (bus_ack) begin
                  state_q      <= RESP;
                  bus_req_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= 1'b0;
                  rsp_rddata_q <= bus_we_q ? 32'h0 : load_word;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q      <= RESP;
                  bus_req_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= 1'b1;
                  rsp_rddata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               rsp_valid_q  <= 1'b0;
               rsp_err_q    <= 1'b0;
               rsp_rddata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign stall      = (state_q != IDLE) | req_valid;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wrdata = bus_wrdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rddata = rsp_rddata_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed vector table, reset/stray-ack sequences,
// and randomized accesses against a behavioural model.
module tb_lsu_bus_ctrl;
   import lsu_bus_ctrl_pkg::*;

   localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, rst_n, req_valid, req_ready, bus_req, bus_we, bus_ack;
   logic        rsp_valid, rsp_err, stall;
   logic [3:0]  mnemonic, bus_be;
   logic [31:0] addr, wr_data, bus_addr, bus_wrdata, bus_rddata, rsp_rddata;

   int nerr = 0;
   int nchk = 0;

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .mnemonic(mnemonic), .addr(addr), .wr_data(wr_data), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wrdata(bus_wrdata),
      .bus_ack(bus_ack), .bus_rddata(bus_rddata), .rsp_valid(rsp_valid),
      .rsp_rddata(rsp_rddata), .rsp_err(rsp_err), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  m;
      logic [31:0] a, wd, rd;
      int          ack_at;   // REQ cycle (1-based) on which the bus acks; out of 1..TO means never
      bit          bus, we, err;
      logic [31:0] baddr, wdata, rdo;
      logic [3:0]  be;
   } vec_t;

   typedef struct {
      bit          ready, stall0, got_rsp, unstable, busy_ready, stall_drop;
      bit          after_valid, after_ready, after_busreq;
      int          rsp_cyc, req_cycles;
      logic        we, err;
      logic [31:0] baddr, wdata, rd;
      logic [3:0]  be;
   } obs_t;

   task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
      end
   endtask

   task automatic chk1(input string tag, input string nm, input logic act, input logic exp);
      chk(tag, nm, {31'h0, act}, {31'h0, exp});
   endtask

   function automatic vec_t mk(logic [3:0] m, logic [31:0] a, logic [31:0] wd, int ack_at,
                               logic [31:0] rd, bit bus, bit we, logic [31:0] baddr,
                               logic [3:0] be, logic [31:0] wdata, bit err, logic [31:0] rdo);
      vec_t v;
      v.m = m; v.a = a; v.wd = wd; v.ack_at = ack_at; v.rd = rd; v.bus = bus; v.we = we;
      v.baddr = baddr; v.be = be; v.wdata = wdata; v.err = err; v.rdo = rdo;
      return v;
   endfunction

   // Reference model: access size, natural offset and byte-wise arithmetic.
   function automatic vec_t model(logic [3:0] m, logic [31:0] a, logic [31:0] wd, int ack_at, logic [31:0] rd);
      vec_t            v;
      int              sz, off;
      bit              ld, st, sgn, mis;
      longint unsigned val;
      v = mk(m, a, wd, ack_at, rd, 0, 0, 0, 0, 0, 0, 0);
      ld  = (m == LB) || (m == LH) || (m == LW) || (m == LBU) || (m == LHU);
      st  = (m == SB) || (m == SH) || (m == SW);
      sgn = (m == LB) || (m == LH);
      sz  = (m == LB || m == LBU || m == SB) ? 1 : (m == LH || m == LHU || m == SH) ? 2 : 4;
      mis = (int'(a[1:0]) % sz) != 0;
      off = (int'(a[1:0]) / sz) * sz;
      v.bus   = (ld || st) && !(TRAP && mis);
      v.err   = !v.bus || !(ack_at >= 1 && ack_at <= TO);
      v.we    = st;
      v.baddr = a & ~32'h3;
      v.be    = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) v.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
      val = (64'(rd) >> (8 * off)) & ((64'h1 << (8 * sz)) - 1);
      if (sgn && (((val >> (8 * sz - 1)) & 64'h1) != 0)) val = val | (~64'h0 << (8 * sz));
      v.rdo = (v.err || st) ? 32'h0 : val[31:0];
      return v;
   endfunction

   // Drive one request, act as the bus slave, and record what the DUT did.
   task automatic access(input vec_t v, input bit hold, output obs_t o);
      o = '{default: 0};
      mnemonic = v.m; addr = v.a; wr_data = v.wd; req_valid = 1'b1;
      #1;
      o.ready = req_ready; o.stall0 = stall;
      @(posedge clk); #1;
      req_valid = hold;
      if (hold) begin mnemonic = SW; addr = $urandom; wr_data = $urandom; end
      for (int c = 1; c <= 40; c++) begin
         if (!stall) o.stall_drop = 1;
         if (req_ready) o.busy_ready = 1;
         if (rsp_valid) begin
            o.got_rsp = 1; o.rsp_cyc = c; o.rd = rsp_rddata; o.err = rsp_err;
            break;
         end
         if (bus_req) begin
            o.req_cycles++;
            if (o.req_cycles == 1) begin
               o.we = bus_we; o.baddr = bus_addr; o.be = bus_be; o.wdata = bus_wrdata;
            end else if (bus_we !== o.we || bus_addr !== o.baddr || bus_be !== o.be || bus_wrdata !== o.wdata) begin
               o.unstable = 1;
            end
         end
         bus_ack    = bus_req && (o.req_cycles == v.ack_at);
         bus_rddata = bus_ack ? v.rd : $urandom;
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      // One more cycle, with a stray ack during RESP when holding.
      req_valid  = 1'b0;
      bus_ack    = hold;
      bus_rddata = $urandom;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      o.after_valid = rsp_valid; o.after_ready = req_ready; o.after_busreq = bus_req;
   endtask

   task automatic apply(input vec_t v, input string tag, input bit hold);
      obs_t o;
      int   exp_rc;
      access(v, hold, o);
      exp_rc = !v.bus ? 0 : (v.ack_at >= 1 && v.ack_at <= TO) ? v.ack_at : TO;
      chk1(tag, "req_ready", o.ready, 1'b1);
      chk1(tag, "stall_idle", o.stall0, 1'b1);
      chk1(tag, "rsp_seen", o.got_rsp, 1'b1);
      chk(tag, "rsp_cycle", o.rsp_cyc, exp_rc + 1);
      chk(tag, "req_cycles", o.req_cycles, exp_rc);
      chk1(tag, "rsp_err", o.err, v.err);
      chk(tag, "rsp_rddata", o.rd, v.rdo);
      if (v.bus) begin
         chk1(tag, "bus_we", o.we, v.we);
         chk(tag, "bus_addr", o.baddr, v.baddr);
         chk(tag, "bus_be", {28'h0, o.be}, {28'h0, v.be});
         if (v.we) chk(tag, "bus_wrdata", o.wdata, v.wdata);
         chk1(tag, "bus_stable", o.unstable, 1'b0);
      end
      chk1(tag, "ready_busy", o.busy_ready, 1'b0);
      chk1(tag, "stall_busy", o.stall_drop, 1'b0);
      chk1(tag, "rsp_pulse", o.after_valid, 1'b0);
      chk1(tag, "ready_after", o.after_ready, 1'b1);
      chk1(tag, "bus_req_after", o.after_busreq, 1'b0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vec_t tbl[$];
      logic [3:0] rm;
      int ra;

      tbl.push_back(mk(LW,  'h100, 0,          3,  'hDEADBEEF, 1, 0, 'h100, 4'hF,    0,          0, 'hDEADBEEF));
      tbl.push_back(mk(LB,  'h103, 0,          1,  'h80FF0000, 1, 0, 'h100, 4'hF,    0,          0, 'hFFFFFF80));
      tbl.push_back(mk(LBU, 'h103, 0,          2,  'h80FF0000, 1, 0, 'h100, 4'hF,    0,          0, 'h00000080));
      tbl.push_back(mk(LH,  'h102, 0,          1,  'h80FF0000, 1, 0, 'h100, 4'hF,    0,          0, 'hFFFF80FF));
      tbl.push_back(mk(LHU, 'h102, 0,          4,  'h80FF0000, 1, 0, 'h100, 4'hF,    0,          0, 'h000080FF));
      tbl.push_back(mk(SB,  'h101, 'h123456AB, 2,  0,          1, 1, 'h100, 4'b0010, 'hABABABAB, 0, 0));
      tbl.push_back(mk(SH,  'h102, 'h123456AB, 1,  0,          1, 1, 'h100, 4'b1100, 'h56AB56AB, 0, 0));
      tbl.push_back(mk(SW,  'h10C, 'hCAFEF00D, 5,  0,          1, 1, 'h10C, 4'hF,    'hCAFEF00D, 0, 0));
      tbl.push_back(mk(LW,  'h200, 0,          0,  'h11111111, 1, 0, 'h200, 4'hF,    0,          1, 0));
      tbl.push_back(mk(LW,  'h204, 0,          16, 'h12345678, 1, 0, 'h204, 4'hF,    0,          0, 'h12345678));
      tbl.push_back(mk(SW,  'h208, 'h5,        0,  0,          1, 1, 'h208, 4'hF,    'h5,        1, 0));
      tbl.push_back(mk(ADD, 'h100, 0,          1,  0,          0, 0, 0,     4'h0,    0,          1, 0));
      tbl.push_back(mk(SB,  'h100, 'h77,       1,  0,          1, 1, 'h100, 4'b0001, 'h77777777, 0, 0));
      tbl.push_back(mk(LB,  'h100, 0,          1,  'h0000007F, 1, 0, 'h100, 4'hF,    0,          0, 'h0000007F));
`ifdef LSU_MISALIGN_TRAP_EN
      tbl.push_back(mk(LW,  'h102, 0,          1,  'hA5A50011, 0, 0, 0,     4'h0,    0,          1, 0));
      tbl.push_back(mk(LH,  'h101, 0,          1,  'h12348001, 0, 0, 0,     4'h0,    0,          1, 0));
      tbl.push_back(mk(SH,  'h103, 'hBEEF,     1,  0,          0, 0, 0,     4'h0,    0,          1, 0));
`else
      tbl.push_back(mk(LW,  'h102, 0,          1,  'hA5A50011, 1, 0, 'h100, 4'hF,    0,          0, 'hA5A50011));
      tbl.push_back(mk(LH,  'h101, 0,          1,  'h12348001, 1, 0, 'h100, 4'hF,    0,          0, 'hFFFF8001));
      tbl.push_back(mk(SH,  'h103, 'hBEEF,     1,  0,          1, 1, 'h100, 4'b1100, 'hBEEFBEEF, 0, 0));
`endif

      rst_n = 1'b0; req_valid = 1'b0; mnemonic = '0; addr = '0; wr_data = '0;
      bus_ack = 1'b0; bus_rddata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("reset", "req_ready", req_ready, 1'b1);
      chk1("reset", "bus_req", bus_req, 1'b0);
      chk1("reset", "rsp_valid", rsp_valid, 1'b0);
      chk1("reset", "rsp_err", rsp_err, 1'b0);
      chk1("reset", "stall", stall, 1'b0);
      chk({"reset"}, "bus_addr", bus_addr, 32'h0);
      chk("reset", "bus_be", {28'h0, bus_be}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ack while idle must be ignored.
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk1("idle_ack", "rsp_valid", rsp_valid, 1'b0);
      chk1("idle_ack", "req_ready", req_ready, 1'b1);

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i), 1'b0);

      // Reset in the middle of a bus cycle, then a late ack.
      mnemonic = LW; addr = 32'h300; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk1("midreset", "bus_req_before", bus_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("midreset", "bus_req", bus_req, 1'b0);
      chk1("midreset", "rsp_valid", rsp_valid, 1'b0);
      chk1("midreset", "req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus_ack = 1'b1; bus_rddata = 32'hFFFFFFFF;
      repeat (2) begin
         @(posedge clk); #1;
         chk1("late_ack", "rsp_valid", rsp_valid, 1'b0);
         chk1("late_ack", "bus_req", bus_req, 1'b0);
         chk1("late_ack", "req_ready", req_ready, 1'b1);
      end
      bus_ack = 1'b0;

      for (int k = 0; k < 60; k++) begin
         rm = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         ra = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
         v  = model(rm, $urandom, $urandom, ra, $urandom);
         apply(v, $sformatf("rand%0d", k), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
